pwr_seq: RTL

Power-up sequencer that sits directly downstream of the reset release synchronizer. It consumes the synchronized, active-high release signal and brings up `STAGES` external domains one at a time. For each domain it raises an enable, waits for that domain's power-good, and then waits a settle time before moving on. It flags a timeout or a power-good loss as a fault with the failing stage index, and supports a software-requested restart with a one-cycle acknowledge.

---
 rtl/pwr_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pwr_seq.sv
// Power-up sequencer: brings up STAGES domains in order after reset release,
// waiting for each power-good plus a settle time, with fault latching and soft restart.
module pwr_seq #(
  parameter int STAGES     = 4,
  parameter int PG_TIMEOUT = 1000,
  parameter int SETTLE_DLY = 500,
  parameter int OFF_DLY    = 200,
  localparam int FSW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_rdy,
  input  logic [STAGES-1:0] stage_pg,
  input  logic              soft_req,
  output logic              soft_ack,
  output logic [STAGES-1:0] stage_en,
  output logic              init_done,
  output logic              busy,
  output logic              fault,
  output logic [FSW-1:0]    fault_stage
);

  localparam int MAX_A = (PG_TIMEOUT > SETTLE_DLY) ? PG_TIMEOUT : SETTLE_DLY;
  localparam int MAX_B = (MAX_A > OFF_DLY) ? MAX_A : OFF_DLY;
  localparam int CW    = (MAX_B > 1) ? $clog2(MAX_B) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EN, S_WAIT_PG, S_SETTLE, S_DONE, S_FAULT, S_OFF
  } state_t;

  state_t          state_q, state_d;
  logic [FSW-1:0]  idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [FSW-1:0]  fault_idx, low_bad;

  logic [STAGES-1:0] stage_en_d;
  logic              soft_ack_d, init_done_d, busy_d, fault_d;
  logic [FSW-1:0]    fault_stage_d;

  // State, counters and every output are registered together so outputs never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_en    <= '0;
      soft_ack    <= 1'b0;
      init_done   <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stage_en    <= stage_en_d;
      soft_ack    <= soft_ack_d;
      init_done   <= init_done_d;
      busy        <= busy_d;
      fault       <= fault_d;
      fault_stage <= fault_stage_d;
    end
  end

  // Next-state: one shared saturating counter serves the timeout, settle and off phases.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fault_idx = idx_q;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    low_bad = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (!stage_pg[i]) low_bad = FSW'(i);
    end

    case (state_q)
      S_IDLE: begin
        if (rst_rdy) begin
          state_d = S_EN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_EN: begin
        state_d = S_WAIT_PG;
        cnt_d   = '0;
      end
      S_WAIT_PG: begin
        if (stage_pg[idx_q]) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(PG_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SETTLE: begin
        if (!stage_pg[idx_q]) begin
          state_d = S_FAULT;
        end else if (cnt_q == CW'(SETTLE_DLY - 1)) begin
          cnt_d = '0;
          if (idx_q == FSW'(STAGES - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_EN;
            idx_d   = idx_q + FSW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        if (!(&stage_pg)) begin
          state_d   = S_FAULT;
          fault_idx = low_bad;
        end else if (soft_req) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        if (soft_req) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      end
      S_OFF: begin
        if (cnt_q == CW'(OFF_DLY - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Loss of the release overrides everything, including a latched fault.
    if (!rst_rdy) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_en_d[i] = (state_d == S_DONE)
                   || ((state_d inside {S_EN, S_WAIT_PG, S_SETTLE}) && (i < int'(idx_d)))
                   || ((state_d inside {S_WAIT_PG, S_SETTLE}) && (i == int'(idx_d)));
    end
    soft_ack_d    = (state_d == S_OFF) && (state_q != S_OFF);
    init_done_d   = (state_d == S_DONE);
    busy_d        = state_d inside {S_EN, S_WAIT_PG, S_SETTLE, S_OFF};
    fault_d       = (state_d == S_FAULT);
    fault_stage_d = '0;
    if (state_d == S_FAULT) begin
      fault_stage_d = (state_q == S_FAULT) ? fault_stage : fault_idx;
    end
  end

endmodule
